// File: rtl/rca_wb_serializer_pkg.sv
// Shared types and constants for the RCA writeback serializer.
//   XLEN            - width of one result register
//   NUM_WRITE_PORTS - number of RCA result ports
//   ID_WIDTH        - width of the RCA instruction id (id_t)
//   rca_wb_state_t  - serializer FSM state encoding
package rca_wb_serializer_pkg;

    localparam int XLEN            = 32;
    localparam int NUM_WRITE_PORTS = 5;
    localparam int ID_WIDTH        = 3;
    localparam int REG_ADDR_W      = 5;

    typedef logic [ID_WIDTH-1:0] id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2
    } rca_wb_state_t;

endpackage

// File: rtl/rca_wb_serializer_prio_enc.sv
// Lowest-set-bit priority encoder.
//   i_req   - request vector
//   o_found - at least one request bit is set
//   o_idx   - index of the lowest set bit (0 when nothing is set)
module rca_wb_prio_enc #(
    parameter int N    = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rca_wb_serializer.sv
// Captures one multi-port RCA result and drains it into the register file
// through a single write port, then pulses commit with the instruction id.
//   clk, rst      - clock, synchronous active-high reset
//   rca_*         - RCA writeback interface (rca_ready back-pressures it)
//   rf_*          - register file write port (rf_gnt accepts a write)
//   commit_*      - one-cycle completion pulse carrying the instruction id
//
// state  | meaning
// IDLE   | ready for a new result
// DRAIN  | issuing pending register writes, lowest port first
// COMMIT | commit pulse for the drained result
module rca_wb_serializer
    import rca_wb_serializer_pkg::*;
#(
    parameter int XLEN            = rca_wb_serializer_pkg::XLEN,
    parameter int NUM_WRITE_PORTS = rca_wb_serializer_pkg::NUM_WRITE_PORTS,
    parameter int ID_WIDTH        = $bits(id_t)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rca_done,
    output logic                            rca_ready,
    input  logic [ID_WIDTH-1:0]             rca_id,
    input  logic [NUM_WRITE_PORTS*XLEN-1:0] rca_rd,
    input  logic [NUM_WRITE_PORTS*5-1:0]    rca_rd_addr,
    input  logic [NUM_WRITE_PORTS-1:0]      rca_rd_valid,
    output logic                            rf_we,
    output logic [4:0]                      rf_waddr,
    output logic [XLEN-1:0]                 rf_wdata,
    input  logic                            rf_gnt,
    output logic                            commit_valid,
    output logic [ID_WIDTH-1:0]             commit_id
);

    localparam int IDX_W = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;

    rca_wb_state_t                   r_state;
    logic [NUM_WRITE_PORTS*XLEN-1:0] r_rd;
    logic [NUM_WRITE_PORTS*5-1:0]    r_addr;
    logic [ID_WIDTH-1:0]             r_id;
    logic [NUM_WRITE_PORTS-1:0]      r_pending;
    logic                            r_rca_ready;
    logic                            r_commit_valid;
    logic [ID_WIDTH-1:0]             r_commit_id;

    logic                            w_accept;
    logic [NUM_WRITE_PORTS-1:0]      w_new_pending;
    logic [NUM_WRITE_PORTS-1:0]      w_sel_onehot;
    logic [NUM_WRITE_PORTS-1:0]      w_pending_next;
    logic                            w_found;
    logic [IDX_W-1:0]                w_idx;

    rca_wb_prio_enc #(
        .N     (NUM_WRITE_PORTS),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .i_req   (r_pending),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign w_accept = rca_done && r_rca_ready;

    // Writes to x0 never enter the pending mask.
    always_comb begin
        w_new_pending = '0;
        for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
            w_new_pending[i] = rca_rd_valid[i] && (rca_rd_addr[i*5 +: 5] != 5'd0);
        end
    end

    assign w_sel_onehot   = NUM_WRITE_PORTS'(1) << w_idx;
    assign w_pending_next = r_pending & ~w_sel_onehot;

    assign rf_we    = (r_state == DRAIN) && w_found;
    assign rf_waddr = rf_we ? r_addr[int'(w_idx)*5 +: 5] : 5'd0;
    assign rf_wdata = rf_we ? r_rd[int'(w_idx)*XLEN +: XLEN] : '0;

    assign rca_ready    = r_rca_ready;
    assign commit_valid = r_commit_valid;
    assign commit_id    = r_commit_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_rd           <= '0;
            r_addr         <= '0;
            r_id           <= '0;
            r_pending      <= '0;
            r_rca_ready    <= 1'b1;
            r_commit_valid <= 1'b0;
            r_commit_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rd        <= rca_rd;
                        r_addr      <= rca_rd_addr;
                        r_id        <= rca_id;
                        r_pending   <= w_new_pending;
                        r_rca_ready <= 1'b0;
                        if (w_new_pending != '0) begin
                            r_state <= DRAIN;
                        end else begin
                            // Nothing to write: commit straight away.
                            r_state        <= COMMIT;
                            r_commit_valid <= 1'b1;
                            r_commit_id    <= rca_id;
                        end
                    end
                end
                DRAIN: begin
                    if (rf_gnt) begin
                        r_pending <= w_pending_next;
                        if (w_pending_next == '0) begin
                            r_state        <= COMMIT;
                            r_commit_valid <= 1'b1;
                            r_commit_id    <= r_id;
                        end
                    end
                end
                COMMIT: begin
                    r_state        <= IDLE;
                    r_commit_valid <= 1'b0;
                    r_rca_ready    <= 1'b1;
                end
                default: begin
                    r_state        <= IDLE;
                    r_pending      <= '0;
                    r_commit_valid <= 1'b0;
                    r_rca_ready    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_wb_serializer.sv
module tb_rca_wb_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         rca_done;
    logic         rca_ready;
    logic [2:0]   rca_id;
    logic [159:0] rca_rd;
    logic [24:0]  rca_rd_addr;
    logic [4:0]   rca_rd_valid;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic         rf_gnt;
    logic         commit_valid;
    logic [2:0]   commit_id;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    // rf_d: what the DUT actually wrote; rf_m: what the reference says it should hold.
    logic [31:0] rf_d [32];
    logic [31:0] rf_m [32];
    bit          written [32];

    rca_wb_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .rca_done     (rca_done),
        .rca_ready    (rca_ready),
        .rca_id       (rca_id),
        .rca_rd       (rca_rd),
        .rca_rd_addr  (rca_rd_addr),
        .rca_rd_valid (rca_rd_valid),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_gnt       (rf_gnt),
        .commit_valid (commit_valid),
        .commit_id    (commit_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && rf_we && rf_gnt) rf_d[rf_waddr] <= rf_wdata;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_noise();
        rca_done     = 1'($urandom_range(0, 1));
        rca_id       = 3'($urandom);
        rca_rd_valid = 5'($urandom);
        rca_rd_addr  = 25'($urandom);
        rca_rd       = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic send(input logic [4:0] v, input logic [24:0] a, input logic [159:0] d,
                        input logic [2:0] id, input int first_stall, input int stall_pct);
        wr_t q[$];
        wr_t w;
        int  cyc;
        int  k;
        bit  g;
        for (int i = 0; i < 5; i++) begin
            if (v[i] && a[i*5 +: 5] != 5'd0) begin
                w.a = a[i*5 +: 5];
                w.d = d[i*32 +: 32];
                q.push_back(w);
            end
        end
        k = q.size();
        chk("ready_before_accept", 64'(rca_ready), 64'd1);
        rca_done     = 1'b1;
        rca_rd_valid = v;
        rca_rd_addr  = a;
        rca_rd       = d;
        rca_id       = id;
        rf_gnt       = 1'($urandom_range(0, 1));
        @(negedge clk);
        cyc = 0;
        while (q.size() > 0 && cyc < 200) begin
            g = (cyc >= first_stall) && ($urandom_range(0, 99) >= stall_pct);
            rf_gnt = g;
            drive_noise();
            chk("rf_we_drain", 64'(rf_we), 64'd1);
            chk("rf_waddr", 64'(rf_waddr), 64'(q[0].a));
            chk("rf_wdata", 64'(rf_wdata), 64'(q[0].d));
            chk("ready_busy", 64'(rca_ready), 64'd0);
            chk("no_early_commit", 64'(commit_valid), 64'd0);
            if (g) begin
                w = q.pop_front();
                rf_m[w.a]    = w.d;
                written[w.a] = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        chk("drain_done_in_budget", 64'(q.size()), 64'd0);
        if (first_stall == 0 && stall_pct == 0) chk("latency", 64'(cyc), 64'(k));
        chk("commit_valid", 64'(commit_valid), 64'd1);
        chk("commit_id", 64'(commit_id), 64'(id));
        chk("rf_we_commit", 64'(rf_we), 64'd0);
        chk("ready_commit", 64'(rca_ready), 64'd0);
        drive_noise();
        rf_gnt = 1'($urandom_range(0, 1));
        @(negedge clk);
        rca_done = 1'b0;
        chk("commit_one_cycle", 64'(commit_valid), 64'd0);
        chk("ready_after_commit", 64'(rca_ready), 64'd1);
        chk("rf_we_idle", 64'(rf_we), 64'd0);
    endtask

    initial begin
        logic [24:0]  a;
        logic [159:0] d;
        rst          = 1'b1;
        rca_done     = 1'b0;
        rca_id       = '0;
        rca_rd       = '0;
        rca_rd_addr  = '0;
        rca_rd_valid = '0;
        rf_gnt       = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rf_m[i]    = '0;
            written[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 64'(rca_ready), 64'd1);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_commit_valid", 64'(commit_valid), 64'd0);
        chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_commit_id", 64'(commit_id), 64'd0);

        // Full mask, no stall
        send(5'b11111, {5'd5, 5'd4, 5'd3, 5'd2, 5'd1},
             {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0}, 3'd5, 0, 0);
        // Sparse mask with an x0 write on port 2
        send(5'b10101, {5'd9, 5'd3, 5'd0, 5'd4, 5'd7},
             {32'hD4, 32'hD3, 32'hD2, 32'hD1, 32'hD0}, 3'd1, 0, 0);
        // Empty mask
        send(5'b00000, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5}, {5{32'hFFFF_0000}}, 3'd3, 0, 0);
        // Grant held off for three cycles on the first write
        send(5'b00011, {5'd0, 5'd0, 5'd0, 5'd6, 5'd4},
             {32'h0, 32'h0, 32'h0, 32'hBEEF, 32'hCAFE}, 3'd6, 3, 0);
        // Duplicate destination x10 on ports 1 and 3
        send(5'b01010, {5'd0, 5'd10, 5'd0, 5'd10, 5'd0},
             {32'h0, 32'h33, 32'h0, 32'h11, 32'h0}, 3'd2, 0, 0);
        chk("dup_final_value", 64'(rf_d[10]), 64'h33);

        for (int n = 0; n < 40; n++) begin
            a = 25'($urandom);
            if ($urandom_range(0, 3) == 0) a[$urandom_range(0, 4)*5 +: 5] = 5'd0;
            d = {$urandom, $urandom, $urandom, $urandom, $urandom};
            send(5'($urandom), a, d, 3'($urandom), $urandom_range(0, 2), $urandom_range(0, 50));
        end

        for (int i = 0; i < 32; i++) begin
            if (written[i]) chk("rf_final_state", 64'(rf_d[i]), 64'(rf_m[i]));
        end

        // Reset during the second write of a four-write result
        rca_done     = 1'b1;
        rca_rd_valid = 5'b01111;
        rca_rd_addr  = {5'd0, 5'd4, 5'd3, 5'd2, 5'd1};
        rca_rd       = {$urandom, $urandom, $urandom, $urandom, $urandom};
        rca_id       = 3'd7;
        rf_gnt       = 1'b1;
        @(negedge clk);
        rca_done = 1'b0;
        chk("rstmid_first_we", 64'(rf_we), 64'd1);
        chk("rstmid_first_addr", 64'(rf_waddr), 64'd1);
        @(negedge clk);
        chk("rstmid_second_addr", 64'(rf_waddr), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_rf_we", 64'(rf_we), 64'd0);
        chk("rstmid_ready", 64'(rca_ready), 64'd1);
        chk("rstmid_commit", 64'(commit_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rstmid_no_commit", 64'(commit_valid), 64'd0);
            chk("rstmid_no_write", 64'(rf_we), 64'd0);
            @(negedge clk);
        end
        send(5'b00110, {5'd0, 5'd0, 5'd12, 5'd11, 5'd0},
             {32'h0, 32'h0, 32'h1234, 32'h5678, 32'h0}, 3'd4, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
